lcd_controller: RTL and testbench

LCD_CONTROLLER -- requirements
Module: lcd_controller

---
 rtl/lcd_controller.sv | 204 ++++++++++++++++++++
 tb/tb_lcd_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_controller.sv
// HD44780-style character LCD controller: CPU command FIFO feeding a
// setup/pulse/hold/exec bus sequencer, plus power and status registers.
module lcd_controller #(
  parameter int SETUP_CYC     = 2,
  parameter int PULSE_CYC     = 12,
  parameter int HOLD_CYC      = 2,
  parameter int EXEC_CYC      = 2000,
  parameter int EXEC_LONG_CYC = 80000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_wren,
  input  logic        i_ctrl_wren,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_status,
  output logic [31:0] o_io_lcd
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_B = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D = (MAX_C > EXEC_LONG_CYC) ? MAX_C : EXEC_LONG_CYC;
  localparam int TMR_W = ($clog2(MAX_D) > 20) ? $clog2(MAX_D) : 20;

  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1'b1);
  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] EXEC_LD  = TMR_W'(EXEC_CYC - 1);
  localparam logic [TMR_W-1:0] LONG_LD  = TMR_W'(EXEC_LONG_CYC - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ZERO = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_nxt;
  logic [8:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             r_ovf;
  logic             r_on;
  logic             r_en;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_long;
  logic             w_busy;
  logic             w_en_nxt;
  logic [8:0]       w_head;
  logic [2:0]       w_cnt3;
  logic             w_unused_wdata;

  // Full is judged on the registered count, so a push into a full FIFO is
  // dropped even if the sequencer pops on the same edge.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == CNT_ZERO);
  assign w_push  = i_cmd_wren & ~w_full;
  assign w_head  = r_mem[r_rptr];
  assign w_long  = ~r_rs & ((r_data == 8'h01) | (r_data == 8'h02));
  assign w_busy  = (r_state != S_IDLE) | ~w_empty;
  assign w_cnt3  = 3'(r_count);
  assign w_unused_wdata = ^{i_wdata[31:10], i_wdata[8]};

  assign o_io_lcd = {r_on, 20'd0, r_en, r_rs, 1'b0, r_data};
  assign o_status = {25'd0, w_cnt3, r_ovf, w_empty, w_full, w_busy};

  // FIFO storage: holds {RS, DATA}; contents are don't-care while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_wdata[9], i_wdata[7:0]};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Power bit and sticky overflow; an explicit clear beats a new overflow.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_on  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (i_ctrl_wren) begin
        r_on <= i_wdata[0];
      end
      if (i_ctrl_wren && i_wdata[1]) begin
        r_ovf <= 1'b0;
      end else if (i_cmd_wren && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Sequencer registers; EN is registered so it drops on reset without glitches.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_tmr   <= TMR_ZERO;
      r_en    <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_en    <= w_en_nxt;
      if (w_pop) begin
        r_rs   <= w_head[8];
        r_data <= w_head[7:0];
      end
    end
  end

  // Next-state logic: each phase loads N-1 on entry and advances when the timer hits zero.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_tmr_nxt   = SETUP_LD;
        end else begin
          w_tmr_nxt   = TMR_ZERO;
        end
      end
      S_SETUP: begin
        if (r_tmr == TMR_ZERO) begin
          w_state_nxt = S_PULSE;
          w_tmr_nxt   = PULSE_LD;
        end else begin
          w_tmr_nxt   = r_tmr - TMR_ONE;
        end
      end
      S_PULSE: begin
        if (r_tmr == TMR_ZERO) begin
          w_state_nxt = S_HOLD;
          w_tmr_nxt   = HOLD_LD;
        end else begin
          w_tmr_nxt   = r_tmr - TMR_ONE;
        end
      end
      S_HOLD: begin
        if (r_tmr == TMR_ZERO) begin
          w_state_nxt = S_EXEC;
          w_tmr_nxt   = w_long ? LONG_LD : EXEC_LD;
        end else begin
          w_tmr_nxt   = r_tmr - TMR_ONE;
        end
      end
      S_EXEC: begin
        if (r_tmr == TMR_ZERO) begin
          w_state_nxt = S_IDLE;
          w_tmr_nxt   = TMR_ZERO;
        end else begin
          w_tmr_nxt   = r_tmr - TMR_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = TMR_ZERO;
      end
    endcase
    w_en_nxt = (w_state_nxt == S_PULSE);
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Self-checking bench for lcd_controller: vector table of single transfers,
// hand-written overflow/control/reset sequences, and randomized traffic.
module tb_lcd_controller;
  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int HOLD  = 2;
  localparam int EXEC  = 5;
  localparam int LONG  = 10;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_wren = 1'b0;
  logic        i_ctrl_wren = 1'b0;
  logic [31:0] i_wdata = 32'h0;
  logic [31:0] o_status;
  logic [31:0] o_io_lcd;

  lcd_controller #(
    .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
    .EXEC_CYC(EXEC), .EXEC_LONG_CYC(LONG), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_wren(i_cmd_wren),
    .i_ctrl_wren(i_ctrl_wren), .i_wdata(i_wdata),
    .o_status(o_status), .o_io_lcd(o_io_lcd)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // EN pulse monitor: records RS/DATA at each rising EN, sampled on the falling clock.
  logic       prev_en = 1'b0;
  logic [9:0] cap_q[$];
  always @(negedge i_clk) begin
    if (o_io_lcd[10] && !prev_en) cap_q.push_back(o_io_lcd[9:0]);
    prev_en <= o_io_lcd[10];
  end

  // Reference model: a queue of pending entries plus the timeline of the last transfer.
  logic [8:0] mq[$];
  int         m_t;
  int         m_last_pop;
  int         m_total;
  logic [8:0] m_cur;
  logic       m_on;
  logic       m_ovf;

  function automatic int xfer_len(input logic [8:0] item);
    return SETUP + PULSE + HOLD +
           ((!item[8] && (item[7:0] == 8'h01 || item[7:0] == 8'h02)) ? LONG : EXEC);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_t = 0;
    m_last_pop = -1000;
    m_total = 0;
    m_cur = 9'h0;
    m_on = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic m_step(input logic cmd, input logic ctrl, input logic [31:0] wd,
                        output logic [31:0] exp_lcd, output logic [31:0] exp_stat);
    logic full_before;
    logic en;
    logic busy;
    logic emp;
    logic fl;
    int   e;
    full_before = (mq.size() == DEPTH);
    if (mq.size() > 0 && (m_t - 1 >= m_last_pop + m_total)) begin
      m_cur = mq.pop_front();
      m_last_pop = m_t;
      m_total = xfer_len(m_cur);
    end
    if (cmd && !full_before) mq.push_back({wd[9], wd[7:0]});
    if (ctrl && wd[1]) m_ovf = 1'b0;
    else if (cmd && full_before) m_ovf = 1'b1;
    if (ctrl) m_on = wd[0];
    e = m_t - m_last_pop;
    en = (e >= SETUP) && (e < SETUP + PULSE);
    busy = (e < m_total) || (mq.size() != 0);
    emp = (mq.size() == 0);
    fl = (mq.size() == DEPTH);
    exp_lcd = {m_on, 20'd0, en, m_cur[8], 1'b0, m_cur[7:0]};
    exp_stat = {25'd0, 3'(mq.size()), m_ovf, emp, fl, busy};
    m_t++;
  endtask

  typedef struct {
    logic [31:0] wdata;
    logic [9:0]  exp_lcd;
    int          exp_fall;
  } vec_t;
  vec_t vecs[7];

  int          en_first;
  int          en_cnt;
  int          fall;
  int          waited;
  logic [9:0]  lcd10;
  logic        c;
  logic        k;
  logic [31:0] wd;
  logic [31:0] el;
  logic [31:0] es;

  initial begin
    vecs[0] = '{32'h0000_0241, 10'h241, 13};
    vecs[1] = '{32'h0000_0001, 10'h001, 18};
    vecs[2] = '{32'h0000_0002, 10'h002, 18};
    vecs[3] = '{32'h0000_0201, 10'h201, 13};
    vecs[4] = '{32'h0000_0003, 10'h003, 13};
    vecs[5] = '{32'h0000_0000, 10'h000, 13};
    vecs[6] = '{32'hFFFF_FD01, 10'h001, 18};

    #2 i_reset = 1'b0;
    tick(); tick();
    chk("reset_lcd", o_io_lcd, 32'h0);
    chk("reset_status", o_status, 32'h4);
    i_reset = 1'b1;
    tick();
    chk("post_reset_lcd", o_io_lcd, 32'h0);
    chk("post_reset_status", o_status, 32'h4);

    // Single transfers: data latch, EN window, busy-fall latency per entry.
    for (int r = 0; r < 7; r++) begin
      i_cmd_wren = 1'b1;
      i_wdata = vecs[r].wdata;
      tick();
      i_cmd_wren = 1'b0;
      i_wdata = 32'h0;
      chk($sformatf("vec%0d_push_status", r), o_status, 32'h11);
      en_first = -1; en_cnt = 0; fall = -1; lcd10 = 10'h0;
      for (int n = 1; n <= 40; n++) begin
        tick();
        if (n == 1) lcd10 = o_io_lcd[9:0];
        if (o_io_lcd[10]) begin
          en_cnt++;
          if (en_first < 0) en_first = n;
        end
        if (!o_status[0]) begin
          fall = n;
          break;
        end
      end
      chk($sformatf("vec%0d_data", r), {22'd0, lcd10}, {22'd0, vecs[r].exp_lcd});
      chk($sformatf("vec%0d_en_first", r), en_first, 1 + SETUP);
      chk($sformatf("vec%0d_en_len", r), en_cnt, PULSE);
      chk($sformatf("vec%0d_busy_fall", r), fall, vecs[r].exp_fall);
    end

    // Overflow: six back-to-back pushes, sixth dropped.
    cap_q.delete();
    for (int j = 0; j < 6; j++) begin
      i_cmd_wren = 1'b1;
      i_wdata = 32'h230 + j;
      tick();
    end
    i_cmd_wren = 1'b0;
    i_wdata = 32'h0;
    chk("ovf_status", o_status, 32'h4B);
    waited = -1;
    for (int n = 0; n < 200; n++) begin
      if (!o_status[0]) begin
        waited = n;
        break;
      end
      tick();
    end
    chk("ovf_drain_timeout", (waited < 0) ? 32'h1 : 32'h0, 32'h0);
    chk("ovf_pulse_count", cap_q.size(), 5);
    for (int m = 0; m < cap_q.size() && m < 5; m++)
      chk($sformatf("ovf_pulse%0d", m), {22'd0, cap_q[m]}, 32'h230 + m);
    chk("ovf_sticky", o_status, 32'h0C);

    // Control writes: power on without pulses, then clear overflow.
    cap_q.delete();
    i_ctrl_wren = 1'b1;
    i_wdata = 32'h1;
    tick();
    i_ctrl_wren = 1'b0;
    i_wdata = 32'h0;
    chk("ctrl_on_lcd", o_io_lcd, 32'h8000_0234);
    chk("ctrl_on_status", o_status, 32'h0C);
    repeat (20) tick();
    chk("ctrl_no_pulse", cap_q.size(), 0);
    i_ctrl_wren = 1'b1;
    i_wdata = 32'h3;
    tick();
    i_ctrl_wren = 1'b0;
    i_wdata = 32'h0;
    chk("ctrl_clr_status", o_status, 32'h4);
    chk("ctrl_clr_on", {31'd0, o_io_lcd[31]}, 32'h1);

    // Fill, then overflow with a simultaneous clear; then reset mid-pulse.
    for (int j = 0; j < 6; j++) begin
      i_cmd_wren = 1'b1;
      i_ctrl_wren = (j == 5) ? 1'b1 : 1'b0;
      i_wdata = (j == 5) ? 32'h2A7 : 32'h2A0 + j;
      tick();
    end
    i_cmd_wren = 1'b0;
    i_ctrl_wren = 1'b0;
    i_wdata = 32'h0;
    chk("clear_wins_status", o_status, 32'h43);
    waited = -1;
    for (int n = 0; n < 20; n++) begin
      if (o_io_lcd[10]) begin
        waited = n;
        break;
      end
      tick();
    end
    chk("pulse_wait_timeout", (waited < 0) ? 32'h1 : 32'h0, 32'h0);
    #2 i_reset = 1'b0;
    #1;
    chk("async_reset_en", {31'd0, o_io_lcd[10]}, 32'h0);
    chk("async_reset_lcd", o_io_lcd, 32'h0);
    chk("async_reset_status", o_status, 32'h4);
    cap_q.delete();
    tick();
    i_reset = 1'b1;
    tick();
    chk("abort_status", o_status, 32'h4);
    repeat (80) tick();
    chk("abort_no_pulse", cap_q.size(), 0);
    chk("abort_lcd", o_io_lcd, 32'h0);

    // Randomized traffic against the reference model.
    i_reset = 1'b0;
    tick(); tick();
    i_reset = 1'b1;
    m_reset();
    for (int i = 0; i < 1200; i++) begin
      c = ((i / 150) % 2 == 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      k = ($urandom_range(0, 29) == 0);
      wd = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        wd[9] = 1'b0;
        wd[7:0] = 8'($urandom_range(1, 2));
      end
      i_cmd_wren = c;
      i_ctrl_wren = k;
      i_wdata = wd;
      m_step(c, k, wd, el, es);
      tick();
      chk($sformatf("rand%0d_lcd", i), o_io_lcd, el);
      chk($sformatf("rand%0d_status", i), o_status, es);
    end
    i_cmd_wren = 1'b0;
    i_ctrl_wren = 1'b0;
    i_wdata = 32'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
